// File: rtl/multicycle_controller_if.sv
// Control-path bundle between the multicycle sequencer and the picoMIPS datapath/IO.
// master = controller side, slave = datapath/IO side.
interface multicycle_controller_if #(
    parameter int OP_W = 6,
    parameter int F_W  = 3,
    parameter int FL_W = 4
) ();
    logic            run;
    logic [OP_W-1:0] opCode;
    logic [FL_W-1:0] aluFlags;
    logic            inValid;
    logic            outAck;
    logic            irLoad;
    logic            pcInc;
    logic            pcBranchAbs;
    logic            pcBranchRel;
    logic            regWrite;
    logic            immSel;
    logic            inSel;
    logic [F_W-1:0]  aluFunction;
    logic            inAck;
    logic            outValid;
    logic            halted;
    logic            illegal;
    logic [FL_W-1:0] flags;

    modport master (
        input  run, opCode, aluFlags, inValid, outAck,
        output irLoad, pcInc, pcBranchAbs, pcBranchRel, regWrite,
               immSel, inSel, aluFunction, inAck, outValid,
               halted, illegal, flags
    );

    modport slave (
        output run, opCode, aluFlags, inValid, outAck,
        input  irLoad, pcInc, pcBranchAbs, pcBranchRel, regWrite,
               immSel, inSel, aluFunction, inAck, outValid,
               halted, illegal, flags
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer for the picoMIPS CPU.
// Owns the condition-flag register and the IN/OUT handshakes.
module multicycle_controller #(
    parameter int OP_W = 6,
    parameter int F_W  = 3,
    parameter int FL_W = 4
) (
    input  logic                    clk,
    input  logic                    nRst,
    multicycle_controller_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [FL_W-1:0] r_flags;

    logic w_isAlu;
    logic w_isNop;
    logic w_isJmp;
    logic w_isBr;
    logic w_isIn;
    logic w_isOut;
    logic w_isHalt;
    logic w_taken;
    logic w_aluPhase;

    assign w_isAlu  = (bus.opCode[OP_W-1 -: 2] == 2'b01);
    assign w_isNop  = (bus.opCode == OP_W'('h00));
    assign w_isJmp  = (bus.opCode == OP_W'('h20));
    assign w_isBr   = (bus.opCode >= OP_W'('h21)) &&
                      (bus.opCode <= OP_W'('h24));
    assign w_isIn   = (bus.opCode == OP_W'('h30));
    assign w_isOut  = (bus.opCode == OP_W'('h31));
    assign w_isHalt = (bus.opCode == OP_W'('h3F));

    // Branch conditions look at the registered flags, never the live ALU flags.
    always_comb begin
        w_taken = 1'b0;
        unique case (1'b1)
            bus.opCode == OP_W'('h21): w_taken = r_flags[0];
            bus.opCode == OP_W'('h22): w_taken = ~r_flags[0];
            bus.opCode == OP_W'('h23): w_taken = r_flags[2];
            bus.opCode == OP_W'('h24): w_taken = r_flags[1];
            default:                   w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_flags <= '0;
        end else if (r_state == S_WRITEBACK) begin
            r_flags <= bus.aluFlags;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_FETCH:     if (bus.run) w_next = S_DECODE;
            S_DECODE:    w_next = S_EXECUTE;
            S_EXECUTE: begin
                unique case (1'b1)
                    w_isAlu:  w_next = S_WRITEBACK;
                    w_isHalt: w_next = S_HALT;
                    w_isIn:   if (bus.inValid) w_next = S_FETCH;
                    w_isOut:  if (bus.outAck) w_next = S_FETCH;
                    default:  w_next = S_FETCH;
                endcase
            end
            S_WRITEBACK: w_next = S_FETCH;
            S_HALT:      w_next = S_HALT;
            default:     w_next = S_FETCH;
        endcase
    end

    assign w_aluPhase = w_isAlu && ((r_state == S_DECODE) ||
                                    (r_state == S_EXECUTE) ||
                                    (r_state == S_WRITEBACK));

    always_comb begin
        bus.irLoad      = 1'b0;
        bus.pcInc       = 1'b0;
        bus.pcBranchAbs = 1'b0;
        bus.pcBranchRel = 1'b0;
        bus.regWrite    = 1'b0;
        bus.inSel       = 1'b0;
        bus.inAck       = 1'b0;
        bus.outValid    = 1'b0;
        bus.halted      = 1'b0;
        bus.illegal     = 1'b0;
        bus.immSel      = w_aluPhase & bus.opCode[F_W];
        bus.aluFunction = w_aluPhase ? bus.opCode[F_W-1:0] : '0;
        unique case (r_state)
            // Gated so that the bus is quiet while reset is held.
            S_FETCH:     bus.irLoad = bus.run & nRst;
            S_DECODE:    ;
            S_EXECUTE: begin
                unique case (1'b1)
                    w_isAlu, w_isHalt: ;
                    w_isNop: bus.pcInc = 1'b1;
                    w_isJmp: bus.pcBranchAbs = 1'b1;
                    w_isBr: begin
                        bus.pcBranchRel = w_taken;
                        bus.pcInc       = ~w_taken;
                    end
                    w_isIn: begin
                        bus.inAck    = bus.inValid;
                        bus.inSel    = bus.inValid;
                        bus.regWrite = bus.inValid;
                        bus.pcInc    = bus.inValid;
                    end
                    w_isOut: begin
                        bus.outValid = 1'b1;
                        bus.pcInc    = bus.outAck;
                    end
                    default: begin
                        bus.pcInc   = 1'b1;
                        bus.illegal = 1'b1;
                    end
                endcase
            end
            S_WRITEBACK: begin
                bus.regWrite = 1'b1;
                bus.pcInc    = 1'b1;
            end
            S_HALT:      bus.halted = 1'b1;
            default:     ;
        endcase
    end

    assign bus.flags = r_flags;

endmodule
